// File: rtl/spi_pp_pkg.sv
// rtl/spi_pp_pkg.sv - shared constants and types for the SPI ping-pong receive buffer
//
// Purpose: default bank depth, byte width and the read-side FSM state encoding.
// Ports:   none (package).
package spi_pp_pkg;

   localparam int DEPTH_DEFAULT = 16;
   localparam int BYTE_W        = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } rdState_t;

endpackage

// File: rtl/spi_pp_dpram.sv
// rtl/spi_pp_dpram.sv - simple dual-port RAM holding both ping-pong banks
//
// Purpose: 2*DEPTH x BYTE_W storage, one write port and one synchronous read
//          port with one clock of latency. Address is {bank, offset}.
// Ports:   clk              clock
//          we, waddr, wdata write port
//          re, raddr        read request; rdata valid the cycle after re
//          rdata            registered read data
module spi_pp_dpram
   import spi_pp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW:0]       waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic              re,
   input  logic [AW:0]       raddr,
   output logic [BYTE_W-1:0] rdata
);

   logic [BYTE_W-1:0] mem [2*DEPTH];

   // No reset: contents survive reset, and the reader never consumes an
   // unwritten location because it only reads up to the closed length.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/spi_pingpong_rx_buf.sv
// rtl/spi_pingpong_rx_buf.sv - ping-pong byte buffer between an SPI slave and a stream consumer
//
// Purpose: bytes strobed by the SPI slave fill one bank while the other bank,
//          once closed (full or frame end), is streamed out over valid/ready.
// Ports:   clk, rst_n                       clock, async active-low reset
//          byte_received, received_data     byte strobe and data from the SPI slave
//          frame_end                        strobe: SPI frame ended
//          rd_valid, rd_data, rd_last       output byte stream (rd_last = last byte of bank)
//          rd_ready                         consumer accept
//          bank_full                        bit i: bank i closed and owned by the reader
//          overflow, ovf_clear              sticky drop flag and its clear
module spi_pingpong_rx_buf
   import spi_pp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_received,
   input  logic [BYTE_W-1:0] received_data,
   input  logic              frame_end,
   output logic              rd_valid,
   output logic [BYTE_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic [1:0]        bank_full,
   output logic              overflow,
   input  logic              ovf_clear
);

   // write side
   logic          wrBank;
   logic [AW-1:0] wrAddr;
   logic [AW:0]   len [2];
   logic          wrAccept;
   logic          wrFill;
   logic          closeNow;
   logic [AW:0]   closeLen;
   logic [1:0]    setMask;

   // read side
   rdState_t          state, stateNext;
   logic              rdBank, rdBankNext;
   logic [AW-1:0]     rdAddr, rdAddrNext;
   logic [BYTE_W-1:0] rdDataNext;
   logic              rdValidNext, rdLastNext;
   logic [1:0]        clrMask;
   logic              ramRe;
   logic [BYTE_W-1:0] ramQ;
   logic [AW:0]       curLen;

   assign wrAccept = byte_received & ~bank_full[wrBank];
   assign wrFill   = wrAccept && (wrAddr == AW'(DEPTH - 1));
   // A byte arriving with frame_end is written first and then one close
   // covers both; a filling byte already closes, so frame_end adds nothing.
   assign closeNow = wrFill | (frame_end & (wrAccept | (wrAddr != '0)));
   assign closeLen = wrFill   ? (AW+1)'(DEPTH) :
                     wrAccept ? {1'b0, wrAddr} + (AW+1)'(1) :
                                {1'b0, wrAddr};
   assign setMask  = closeNow ? (2'b01 << wrBank) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrBank    <= 1'b0;
         wrAddr    <= '0;
         len[0]    <= '0;
         len[1]    <= '0;
         bank_full <= 2'b00;
         overflow  <= 1'b0;
      end else begin
         if (closeNow) begin
            len[wrBank] <= closeLen;
            wrBank      <= ~wrBank;
            wrAddr      <= '0;
         end else if (wrAccept) begin
            wrAddr <= wrAddr + AW'(1);
         end
         // Writer sets only its own bank, reader clears only its own; they
         // never target the same bit, so both can land in one cycle.
         bank_full <= (bank_full | setMask) & ~clrMask;
         if (byte_received & bank_full[wrBank]) begin
            overflow <= 1'b1;
         end else if (ovf_clear) begin
            overflow <= 1'b0;
         end
      end
   end

   assign curLen = len[rdBank];

   always_comb begin
      stateNext   = state;
      rdBankNext  = rdBank;
      rdAddrNext  = rdAddr;
      rdDataNext  = rd_data;
      rdValidNext = rd_valid;
      rdLastNext  = rd_last;
      ramRe       = 1'b0;
      clrMask     = 2'b00;
      case (state)
         IDLE: begin
            rdValidNext = 1'b0;
            if (bank_full[rdBank]) begin
               rdAddrNext = '0;
               ramRe      = 1'b1;
               stateNext  = FETCH;
            end
         end
         FETCH: begin
            rdDataNext  = ramQ;
            rdValidNext = 1'b1;
            rdLastNext  = ({1'b0, rdAddr} == curLen - (AW+1)'(1));
            stateNext   = STREAM;
         end
         STREAM: begin
            if (rd_ready) begin
               rdValidNext = 1'b0;
               if (rd_last) begin
                  rdLastNext = 1'b0;
                  clrMask    = 2'b01 << rdBank;
                  rdBankNext = ~rdBank;
                  stateNext  = IDLE;
               end else begin
                  rdAddrNext = rdAddr + AW'(1);
                  ramRe      = 1'b1;
                  stateNext  = FETCH;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rdBank   <= 1'b0;
         rdAddr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state    <= stateNext;
         rdBank   <= rdBankNext;
         rdAddr   <= rdAddrNext;
         rd_data  <= rdDataNext;
         rd_valid <= rdValidNext;
         rd_last  <= rdLastNext;
      end
   end

   spi_pp_dpram #(.DEPTH(DEPTH), .AW(AW)) uRam (
      .clk   (clk),
      .we    (wrAccept),
      .waddr ({wrBank, wrAddr}),
      .wdata (received_data),
      .re    (ramRe),
      .raddr ({rdBank, rdAddrNext}),
      .rdata (ramQ)
   );

endmodule
